// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end for a 1-cycle synchronous instruction memory.
// Tracks the PC of the returned word, handles start, stall, one-bubble branch redirect and halt.
module fetch_unit #(
    parameter int unsigned       ADDR_W    = 11,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]       HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              stall_i,
    input  logic              branch_taken_i,
    input  logic [23:0]       branch_offset_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [31:0]       imem_data_i,
    output logic [ADDR_W-1:0] pc_out_o,
    output logic [31:0]       instr_o,
    output logic              instr_valid_o,
    output logic              halted_o,
    output logic [15:0]       fetch_count_o
);
    typedef enum logic [2:0] {IDLE, PRIME, RUN, FLUSH, HALT} state_e;
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, pc_q, pc_d, target, off_w;
    logic [15:0]       cnt_q, cnt_d, cnt_inc;
    logic              hold_q, hold_d;
    logic [31:0]       hold_data_q, hold_data_d, word;
    // The address stays put during a stall but the memory keeps returning the next
    // address's data, so the stalled instruction is captured and replayed from here.
    assign word    = hold_q ? hold_data_q : imem_data_i;
    assign off_w   = ADDR_W'($signed({branch_offset_i, 2'b00}));
    assign target  = pc_q + ADDR_W'(8) + off_w;
    assign cnt_inc = cnt_q + {15'b0, cnt_q != 16'hFFFF};
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= RESET_PC;
            pc_q        <= RESET_PC;
            cnt_q       <= '0;
            hold_q      <= 1'b0;
            hold_data_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            pc_q        <= pc_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_data_q <= hold_data_d;
        end
    end
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_data_d = hold_data_q;
        case (state_q)
            IDLE: state_d = start_i ? PRIME : IDLE;
            PRIME, FLUSH: begin
                pc_d    = addr_q;
                addr_d  = addr_q + ADDR_W'(4);
                hold_d  = 1'b0;
                state_d = RUN;
            end
            RUN: begin
                hold_d = stall_i;
                if (stall_i) begin
                    hold_data_d = word;
                end else if (word == HALT_WORD) begin
                    state_d = HALT;
                end else if (branch_taken_i) begin
                    addr_d  = target;
                    cnt_d   = cnt_inc;
                    state_d = FLUSH;
                end else begin
                    pc_d   = addr_q;
                    addr_d = addr_q + ADDR_W'(4);
                    cnt_d  = cnt_inc;
                end
            end
            HALT: state_d = HALT;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        instr_valid_o = state_q == RUN;
        halted_o      = state_q == HALT;
        instr_o       = instr_valid_o ? word : '0;
        imem_addr_o   = addr_q;
        pc_out_o      = pc_q;
        fetch_count_o = cnt_q;
    end
endmodule
